// File: rtl/mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mul_rr_scheduler
//  Description : Round-robin scheduler sharing one sequential multiplier
//                between NREQ requesters. It latches the granted requester's
//                operands, sequences start/finish, and returns the 2N-bit
//                product with a one-cycle ack. A watchdog aborts the operation
//                with a one-cycle err and a multiplier reset pulse if finish
//                never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_rr_scheduler #(
  parameter int N       = 5,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4*N+8,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_bus,
  input  logic [NREQ*N-1:0] b_bus,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic [2*N-1:0]    result,
  output logic              busy,
  output logic [IDW-1:0]    gnt_id,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  output logic              mul_start,
  output logic              mul_rst,
  input  logic [2*N-1:0]    mul_out,
  input  logic              mul_finish
);

  // Watchdog counter only needs to reach TIMEOUT-1 before RUN is left.
  localparam int              WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]  c_WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW:0]    c_NREQ    = (IDW+1)'(NREQ);

  // Controller states.
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_GAP  = 2'd3;

  // Registered state and its next-state values.
  logic [1:0]      state_q,  state_d;
  logic [IDW-1:0]  ptr_q,    ptr_d;
  logic [IDW-1:0]  gnt_q,    gnt_d;
  logic [N-1:0]    opa_q,    opa_d;
  logic [N-1:0]    opb_q,    opb_d;
  logic [2*N-1:0]  result_q, result_d;
  logic [NREQ-1:0] ack_q,    ack_d;
  logic [NREQ-1:0] err_q,    err_d;
  logic [WDW-1:0]  wdog_q,   wdog_d;
  logic            abort_q,  abort_d;

  // Per-requester operand views of the flat buses.
  logic [N-1:0] w_a_arr [NREQ];
  logic [N-1:0] w_b_arr [NREQ];

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_a_arr[g] = a_bus[g*N +: N];
      assign w_b_arr[g] = b_bus[g*N +: N];
    end
  endgenerate

  // Reduce an index in [0, 2*NREQ-2] back into [0, NREQ-1].
  function automatic logic [IDW:0] f_wrap(input logic [IDW:0] v);
    return (v >= c_NREQ) ? (v - c_NREQ) : v;
  endfunction

  // Arbitration scan, starting at the rotating pointer.
  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [IDW:0]   w_cand;
  logic [IDW:0]   w_ptr_nxt;

  // Pick the first asserted request at or after ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = f_wrap({1'b0, ptr_q} + (IDW+1)'(k));
      if (!w_found && req[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDW-1:0];
      end
    end
    w_ptr_nxt = f_wrap({1'b0, w_pick} + (IDW+1)'(1));
  end

  // Next-state logic for the IDLE -> LOAD -> RUN -> GAP sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    wdog_d   = wdog_q;
    ack_d    = '0;
    err_d    = '0;
    abort_d  = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (w_found) begin
          opa_d   = w_a_arr[w_pick];
          opb_d   = w_b_arr[w_pick];
          gnt_d   = w_pick;
          ptr_d   = w_ptr_nxt[IDW-1:0];
          state_d = c_LOAD;
        end
      end
      c_LOAD: begin
        // Operands have been on mul_a/mul_b for a full cycle before start.
        wdog_d  = '0;
        state_d = c_RUN;
      end
      c_RUN: begin
        wdog_d = wdog_q + 1'b1;
        // finish in the first RUN cycle may be left over from the previous op.
        if (mul_finish && (wdog_q != '0)) begin
          result_d     = mul_out;
          ack_d[gnt_q] = 1'b1;
          state_d      = c_GAP;
        end else if (wdog_q == c_WD_LAST) begin
          result_d     = '0;
          err_d[gnt_q] = 1'b1;
          abort_d      = 1'b1;
          state_d      = c_GAP;
        end
      end
      c_GAP: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      wdog_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
      abort_q  <= abort_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign result    = result_q;
  assign gnt_id    = gnt_q;
  assign mul_a     = opa_q;
  assign mul_b     = opb_q;
  assign busy      = (state_q != c_IDLE);
  assign mul_start = (state_q == c_RUN);
  // The multiplier is held in reset with the system and pulsed after an abort.
  assign mul_rst   = reset | abort_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_rr_scheduler
//  Description : Directed self-checking bench for mul_rr_scheduler with a
//                behavioural multiplier whose finish timing can be steered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_rr_scheduler;

  localparam int N       = 5;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4*N+8;
  localparam int IDW     = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_bus;
  logic [NREQ*N-1:0] b_bus;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic [2*N-1:0]    result;
  logic              busy;
  logic [IDW-1:0]    gnt_id;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic              mul_start;
  logic              mul_rst;
  logic [2*N-1:0]    mul_out;
  logic              mul_finish;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0, err_cnt = 0, both_cnt = 0, multi_cnt = 0, mrst_cnt = 0;
  // 0: finish after N start cycles, 1: never, 2: only at RUN cycle TIMEOUT-1,
  // 3: finish high throughout start (stale-finish case)
  int mode = 0;
  int run_cnt = 0;

  logic [3:0] ra, re;
  int cyc, st, a0, e0, m0;

  logic [3:0] exp2_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         exp2_res [5] = '{9, 16, 25, 36, 9};
  int         exp2_gnt [5] = '{0, 1, 2, 3, 0};
  logic [3:0] exp3_ack [4] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
  int         exp3_res [4] = '{63, 961, 63, 961};

  mul_rr_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a_bus      (a_bus),
    .b_bus      (b_bus),
    .ack        (ack),
    .err        (err),
    .result     (result),
    .busy       (busy),
    .gnt_id     (gnt_id),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_rst    (mul_rst),
    .mul_out    (mul_out),
    .mul_finish (mul_finish)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: counts consecutive start cycles.
  always @(posedge clk) begin
    if (mul_rst || !mul_start) run_cnt <= 0;
    else                       run_cnt <= run_cnt + 1;
  end

  always_comb begin
    mul_finish = 1'b0;
    case (mode)
      0:       mul_finish = mul_start && (run_cnt >= N);
      2:       mul_finish = mul_start && (run_cnt == TIMEOUT-1);
      3:       mul_finish = mul_start;
      default: mul_finish = 1'b0;
    endcase
    mul_out = '0;
    if (mul_finish) mul_out = {5'b0, mul_a} * {5'b0, mul_b};
  end

  // Pulse statistics.
  always @(negedge clk) begin
    if ((|ack) === 1'b1) ack_cnt <= ack_cnt + 1;
    if ((|err) === 1'b1) err_cnt <= err_cnt + 1;
    if (((|ack) && (|err)) === 1'b1) both_cnt <= both_cnt + 1;
    if ($countones(ack) > 1 || $countones(err) > 1) multi_cnt <= multi_cnt + 1;
    if ((mul_rst && !reset) === 1'b1) mrst_cnt <= mrst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_bus[i*N +: N] = a[N-1:0];
    b_bus[i*N +: N] = b[N-1:0];
  endtask

  // Wait (bounded) for an ack or err pulse; cycles counted from the call.
  task automatic wait_done(output logic [3:0] a_o, output logic [3:0] e_o,
                           output int cyc_o, output int st_o);
    a_o = '0; e_o = '0; cyc_o = 0; st_o = 0;
    for (int i = 1; i <= 100 && cyc_o == 0; i++) begin
      @(negedge clk);
      if (st_o == 0 && mul_start === 1'b1) st_o = i;
      if (((|ack) || (|err)) === 1'b1) begin
        a_o = ack; e_o = err; cyc_o = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; req = '0; a_bus = '0; b_bus = '0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),      0);
    chk("rst_ack",    32'(ack),       0);
    chk("rst_err",    32'(err),       0);
    chk("rst_result", 32'(result),    0);
    chk("rst_gnt",    32'(gnt_id),    0);
    chk("rst_start",  32'(mul_start), 0);
    chk("rst_mula",   32'(mul_a),     0);
    chk("rst_mulrst", 32'(mul_rst),   1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_mulrst", 32'(mul_rst), 0);

    // Single request, 26 x 30
    set_op(0, 26, 30); req = 4'b0001;
    wait_done(ra, re, cyc, st);
    req = '0;
    chk("t1_ack",    32'(ra),     32'b0001);
    chk("t1_err",    32'(re),     0);
    chk("t1_result", 32'(result), 780);
    chk("t1_gnt",    32'(gnt_id), 0);
    chk("t1_lat",    32'(cyc),    N+3);
    chk("t1_start",  32'(st),     2);
    chk("t1_gapbusy",32'(busy),   1);
    @(negedge clk);
    chk("t1_idle",   32'(busy),   0);
    chk("t1_ackone", 32'(ack),    0);
    chk("t1_hold",   32'(result), 780);

    // All four requesting, pointer freshly reset
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, i+3, i+3);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(ra, re, cyc, st);
      chk("t2_ack",    32'(ra),     32'(exp2_ack[j]));
      chk("t2_result", 32'(result), 32'(exp2_res[j]));
      chk("t2_gnt",    32'(gnt_id), 32'(exp2_gnt[j]));
    end
    req = '0;
    @(negedge clk);

    // req[1] held alongside req[2]: strict alternation
    set_op(1, 7, 9); set_op(2, 31, 31);
    req = 4'b0110;
    for (int j = 0; j < 4; j++) begin
      wait_done(ra, re, cyc, st);
      chk("t3_ack",    32'(ra),     32'(exp3_ack[j]));
      chk("t3_result", 32'(result), 32'(exp3_res[j]));
    end
    req = '0;
    @(negedge clk);

    // Watchdog abort, then normal completion
    mode = 1; set_op(3, 5, 6); req = 4'b1000; m0 = mrst_cnt;
    wait_done(ra, re, cyc, st);
    req = '0;
    chk("t4_err",    32'(re),      32'b1000);
    chk("t4_ack",    32'(ra),      0);
    chk("t4_result", 32'(result),  0);
    chk("t4_lat",    32'(cyc),     TIMEOUT+2);
    chk("t4_mulrst", 32'(mul_rst), 1);
    @(negedge clk);
    chk("t4_mulrst_end", 32'(mul_rst), 0);
    chk("t4_busy",       32'(busy),    0);
    chk("t4_rstpulse",   32'(mrst_cnt - m0), 1);
    mode = 0; req = 4'b1000;
    wait_done(ra, re, cyc, st);
    req = '0;
    chk("t4_ack2",    32'(ra),     32'b1000);
    chk("t4_err2",    32'(re),     0);
    chk("t4_result2", 32'(result), 30);
    @(negedge clk);

    // Reset in the middle of RUN
    set_op(1, 10, 10); req = 4'b0010; a0 = ack_cnt; e0 = err_cnt;
    repeat (3) @(negedge clk);
    chk("t5_inrun", 32'(mul_start), 1);
    reset = 1'b1; req = '0;
    @(negedge clk);
    chk("t5_busy",   32'(busy),      0);
    chk("t5_start",  32'(mul_start), 0);
    chk("t5_ack",    32'(ack),       0);
    chk("t5_err",    32'(err),       0);
    chk("t5_result", 32'(result),    0);
    chk("t5_gnt",    32'(gnt_id),    0);
    chk("t5_mula",   32'(mul_a),     0);
    chk("t5_mulrst", 32'(mul_rst),   1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_noack", 32'(ack_cnt - a0), 0);
    chk("t5_noerr", 32'(err_cnt - e0), 0);
    set_op(3, 13, 13); req = 4'b1000;
    wait_done(ra, re, cyc, st);
    req = '0;
    chk("t5_ack2",    32'(ra),     32'b1000);
    chk("t5_result2", 32'(result), 169);
    chk("t5_gnt2",    32'(gnt_id), 3);
    @(negedge clk);

    // finish coinciding with the last watchdog cycle wins
    mode = 2; set_op(0, 3, 4); req = 4'b0001;
    wait_done(ra, re, cyc, st);
    req = '0;
    chk("t6_ack",    32'(ra),     32'b0001);
    chk("t6_err",    32'(re),     0);
    chk("t6_result", 32'(result), 12);
    chk("t6_lat",    32'(cyc),    TIMEOUT+2);
    @(negedge clk);

    // finish already high in the first RUN cycle is ignored
    mode = 3; set_op(2, 17, 3); req = 4'b0100;
    wait_done(ra, re, cyc, st);
    req = '0; mode = 0;
    chk("t7_ack",    32'(ra),     32'b0100);
    chk("t7_result", 32'(result), 51);
    chk("t7_lat",    32'(cyc),    4);
    repeat (2) @(negedge clk);

    chk("both_pulses", 32'(both_cnt),  0);
    chk("multi_hot",   32'(multi_cnt), 0);
    chk("ack_total",   32'(ack_cnt),   14);
    chk("err_total",   32'(err_cnt),   1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
